// File: rtl/d_cache_control_nway.sv
// d_cache_control_nway
//   Control FSM for an N-way set-associative, write-back, write-allocate
//   data cache. It sits between the CPU memory port and physical memory
//   and drives per-way load enables into the cache datapath.
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   hit_vec          per-way tag match AND valid for the current index
//   valid_vec        valid bits of the current set
//   dirty_vec        dirty bits of the current set
//   plru_way         pseudo-LRU victim proposed by the LRU array
//   victim_tag       tag array output for way victim_way
//   mem_address      CPU address
//   mem_read         CPU read request
//   mem_write        CPU write request
//   pmem_resp        physical memory transaction done
//   victim_way       selected way (combinational in S_IDLE, registered otherwise)
//   ld_way           one-hot data/tag array load
//   ld_valid         one-hot valid-bit load (valid_in is tied to 1)
//   ld_dirty         one-hot dirty-bit load
//   dirty_in         value written to the dirty bit
//   ld_lru           update PLRU with the accessed way
//   wr_sel           1 = merge CPU write data, 0 = line from pmem
//   mem_resp         CPU request complete
//   pmem_read        line read request
//   pmem_write       line writeback request
//   pmem_address     line-aligned physical address
module d_cache_control_nway #(
    parameter int WAYS     = 4,
    parameter int TAG_W    = 9,
    parameter int INDEX_W  = 3,
    parameter int OFFSET_W = 4,
    parameter int ADDR_W   = 16,
    localparam int WAY_W   = $clog2(WAYS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WAYS-1:0]   hit_vec,
    input  logic [WAYS-1:0]   valid_vec,
    input  logic [WAYS-1:0]   dirty_vec,
    input  logic [WAY_W-1:0]  plru_way,
    input  logic [TAG_W-1:0]  victim_tag,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              pmem_resp,
    output logic [WAY_W-1:0]  victim_way,
    output logic [WAYS-1:0]   ld_way,
    output logic [WAYS-1:0]   ld_valid,
    output logic [WAYS-1:0]   ld_dirty,
    output logic              dirty_in,
    output logic              ld_lru,
    output logic              wr_sel,
    output logic              mem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_FILL
    } state_t;

    state_t           state, state_next;
    logic [WAY_W-1:0] victim_q;
    logic             capture_victim;

    logic             request;
    logic             hit;
    logic             hit_found;
    logic [WAY_W-1:0] hit_way;
    logic             inv_found;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] miss_victim;
    logic             victim_dirty;
    logic [ADDR_W-1:0] line_address;
    logic [ADDR_W-1:0] wb_address;

    // Byte offset is never needed: every pmem access is line aligned.
    logic unused_offset;
    assign unused_offset = ^mem_address[OFFSET_W-1:0];

    assign request = mem_read | mem_write;
    assign hit     = |hit_vec;

    // Lowest-index priority scans for the hit way and the first invalid way.
    always_comb begin
        hit_way   = '0;
        hit_found = 1'b0;
        inv_way   = '0;
        inv_found = 1'b0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (hit_vec[i] && !hit_found) begin
                hit_way   = WAY_W'(i);
                hit_found = 1'b1;
            end
            if (!valid_vec[i] && !inv_found) begin
                inv_way   = WAY_W'(i);
                inv_found = 1'b1;
            end
        end
    end

    // Fill an empty way before evicting anything; otherwise trust PLRU.
    assign miss_victim  = inv_found ? inv_way : plru_way;
    assign victim_dirty = valid_vec[miss_victim] & dirty_vec[miss_victim];

    assign line_address = {mem_address[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    assign wb_address   = {victim_tag,
                           mem_address[OFFSET_W+INDEX_W-1:OFFSET_W],
                           {OFFSET_W{1'b0}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            victim_q <= '0;
        end else begin
            state <= state_next;
            if (capture_victim) begin
                victim_q <= miss_victim;
            end
        end
    end

    always_comb begin
        state_next     = state;
        capture_victim = 1'b0;
        victim_way     = victim_q;
        ld_way         = '0;
        ld_valid       = '0;
        ld_dirty       = '0;
        dirty_in       = 1'b0;
        ld_lru         = 1'b0;
        wr_sel         = 1'b0;
        mem_resp       = 1'b0;
        pmem_read      = 1'b0;
        pmem_write     = 1'b0;
        pmem_address   = line_address;

        case (state)
            S_IDLE: begin
                victim_way = hit ? hit_way : miss_victim;
                if (request) begin
                    if (hit) begin
                        mem_resp = 1'b1;
                        ld_lru   = 1'b1;
                        // A simultaneous read+write is handled as a write.
                        if (mem_write) begin
                            wr_sel   = 1'b1;
                            ld_way   = WAYS'(1) << hit_way;
                            ld_dirty = WAYS'(1) << hit_way;
                            dirty_in = 1'b1;
                        end
                    end else begin
                        capture_victim = 1'b1;
                        state_next     = victim_dirty ? S_WRITEBACK : S_FILL;
                    end
                end
            end

            S_WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = wb_address;
                if (pmem_resp) begin
                    state_next = S_FILL;
                end
            end

            S_FILL: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    ld_way     = WAYS'(1) << victim_q;
                    ld_valid   = WAYS'(1) << victim_q;
                    ld_dirty   = WAYS'(1) << victim_q;
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule
